// File: rtl/dmem_initiator.sv
// dmem_initiator: MEM-stage initiator that turns EX/MEM load/store controls
// into a single outstanding req/ack transaction toward a variable-latency
// data memory. It stalls the upstream pipeline while waiting, and it loads
// the MEM/WB registers for writeback.
`timescale 1ns/1ps

module dmem_initiator #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              xm_memtoreg,
  input  logic              xm_regwrite,
  input  logic              xm_memread,
  input  logic              xm_memwrite,
  input  logic [31:0]       alu_out,
  input  logic [4:0]        xm_rd,
  input  logic [DATA_W-1:0] xm_md,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              mw_memtoreg,
  output logic              mw_regwrite,
  output logic [31:0]       mw_aluout,
  output logic [DATA_W-1:0] mdr,
  output logic [4:0]        mw_rd,
  output logic              err
);

  typedef enum logic {IDLE, BUSY} state_t;

  // The wait counter runs from 0 up to TIMEOUT-1, so it needs clog2(TIMEOUT) bits.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             acc;
  logic             timeout_hit;

  assign acc         = xm_memread | xm_memwrite;
  assign timeout_hit = (state == BUSY) && !mem_ack && (wait_cnt == CNT_LAST);

  // Freeze upstream while a request is starting or waiting. Release it on the
  // ack cycle and on the abort cycle. Reset forces the stall low at once.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stall = acc;
        BUSY:    stall = !(mem_ack || timeout_hit);
        default: stall = 1'b0;
      endcase
    end
  end

  // Transaction FSM. It also loads the MEM/WB registers and tracks the timeout.
  // A store wins over a read when both are set, so mdr is loaded only when
  // the issued request was a read (mem_we == 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mw_memtoreg <= 1'b0;
      mw_regwrite <= 1'b0;
      mw_aluout   <= '0;
      mw_rd       <= '0;
      mdr         <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            mem_req     <= 1'b1;
            mem_we      <= xm_memwrite;
            mem_addr    <= alu_out[ADDR_W-1:0];
            mem_wdata   <= xm_md;
            wait_cnt    <= '0;
            mw_regwrite <= 1'b0;
            mw_memtoreg <= 1'b0;
            state       <= BUSY;
          end else begin
            mw_memtoreg <= xm_memtoreg;
            mw_regwrite <= xm_regwrite;
            mw_aluout   <= alu_out;
            mw_rd       <= xm_rd;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            mw_memtoreg <= xm_memtoreg;
            mw_regwrite <= xm_regwrite;
            mw_aluout   <= alu_out;
            mw_rd       <= xm_rd;
            if (!mem_we) mdr <= mem_rdata;
            state       <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            mem_req     <= 1'b0;
            err         <= 1'b1;
            mw_memtoreg <= xm_memtoreg;
            mw_regwrite <= xm_regwrite;
            mw_aluout   <= alu_out;
            mw_rd       <= xm_rd;
            if (!mem_we) mdr <= '0;
            state       <= IDLE;
          end else begin
            wait_cnt    <= wait_cnt + CNT_W'(1);
            mw_regwrite <= 1'b0;
            mw_memtoreg <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_initiator.sv
// tb_dmem_initiator: drives whole pipeline operations (ALU op, load, store,
// load+store) with a chosen ack latency. It predicts stall length, memory-side
// outputs and MEM/WB results from a transaction-level model.
`timescale 1ns/1ps

module tb_dmem_initiator;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              rst;
  logic              xm_memtoreg;
  logic              xm_regwrite;
  logic              xm_memread;
  logic              xm_memwrite;
  logic [31:0]       alu_out;
  logic [4:0]        xm_rd;
  logic [DATA_W-1:0] xm_md;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              mw_memtoreg;
  logic              mw_regwrite;
  logic [31:0]       mw_aluout;
  logic [DATA_W-1:0] mdr;
  logic [4:0]        mw_rd;
  logic              err;

  dmem_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .xm_memtoreg(xm_memtoreg), .xm_regwrite(xm_regwrite),
    .xm_memread(xm_memread), .xm_memwrite(xm_memwrite),
    .alu_out(alu_out), .xm_rd(xm_rd), .xm_md(xm_md),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .mw_memtoreg(mw_memtoreg), .mw_regwrite(mw_regwrite), .mw_aluout(mw_aluout),
    .mdr(mdr), .mw_rd(mw_rd), .err(err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: the architectural MEM/WB view, mdr and the sticky error
  logic              expRw;
  logic              expM2r;
  logic [31:0]       expAlu;
  logic [4:0]        expRd;
  logic [DATA_W-1:0] expMdr;
  logic              expErr;

  // Count one comparison and report it if the observed value differs
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkMw(input string tag);
    checkOutput({tag, ".mw_regwrite"}, 64'(mw_regwrite), 64'(expRw));
    checkOutput({tag, ".mw_memtoreg"}, 64'(mw_memtoreg), 64'(expM2r));
    checkOutput({tag, ".mw_aluout"},   64'(mw_aluout),   64'(expAlu));
    checkOutput({tag, ".mw_rd"},       64'(mw_rd),       64'(expRd));
  endtask

  task automatic modelReset();
    expRw = 1'b0; expM2r = 1'b0; expAlu = '0; expRd = '0; expMdr = '0; expErr = 1'b0;
  endtask

  // One pipeline operation. ackCycle is the BUSY cycle (1-based) carrying the
  // ack; 0 or anything beyond TIMEOUT means the responder never answers.
  task automatic applyStimulus(input logic rdEn, input logic wrEn, input logic m2r, input logic rw,
                               input logic [31:0] alu, input logic [4:0] rdst,
                               input logic [DATA_W-1:0] md, input int ackCycle,
                               input logic [DATA_W-1:0] ackData);
    bit                isMem;
    bit                aborted;
    int                lastCycle;
    int                stallCnt;
    logic [ADDR_W-1:0] expAddr;
    isMem   = rdEn | wrEn;
    expAddr = alu[ADDR_W-1:0];
    @(negedge clk);
    xm_memread = rdEn; xm_memwrite = wrEn; xm_memtoreg = m2r; xm_regwrite = rw;
    alu_out = alu; xm_rd = rdst; xm_md = md; mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    if (!isMem) begin
      checkOutput("alu.stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      expRw = rw; expM2r = m2r; expAlu = alu; expRd = rdst;
      checkMw("alu");
      checkOutput("alu.mem_req", 64'(mem_req), 64'd0);
      checkOutput("alu.mdr", 64'(mdr), 64'(expMdr));
      checkOutput("alu.err", 64'(err), 64'(expErr));
      return;
    end
    aborted   = (ackCycle < 1) || (ackCycle > TIMEOUT);
    lastCycle = aborted ? TIMEOUT : ackCycle;
    checkOutput("mem.stall_idle", 64'(stall), 64'd1);
    stallCnt = stall ? 1 : 0;
    @(posedge clk); #1;
    expRw = 1'b0; expM2r = 1'b0;
    for (int b = 1; b <= lastCycle; b++) begin
      if (b > 1) @(negedge clk);
      mem_ack   = (!aborted && b == ackCycle);
      mem_rdata = mem_ack ? ackData : DATA_W'($urandom);
      #1;
      checkOutput("busy.mem_req",   64'(mem_req),   64'd1);
      checkOutput("busy.mem_we",    64'(mem_we),    64'(wrEn));
      checkOutput("busy.mem_addr",  64'(mem_addr),  64'(expAddr));
      checkOutput("busy.mem_wdata", 64'(mem_wdata), 64'(md));
      checkMw("busy");
      checkOutput("busy.stall", 64'(stall), 64'(b < lastCycle));
      if (stall) stallCnt++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    expRw = rw; expM2r = m2r; expAlu = alu; expRd = rdst;
    if (rdEn && !wrEn) expMdr = aborted ? '0 : ackData;
    if (aborted) expErr = 1'b1;
    checkOutput("done.stall_cycles", 64'(stallCnt), 64'(lastCycle));
    checkOutput("done.mem_req", 64'(mem_req), 64'd0);
    checkMw("done");
    checkOutput("done.mdr", 64'(mdr), 64'(expMdr));
    checkOutput("done.err", 64'(err), 64'(expErr));
  endtask

  // An ack arriving while idle with no access pending must change nothing
  task automatic idleAck();
    @(negedge clk);
    xm_memread = 1'b0; xm_memwrite = 1'b0; xm_memtoreg = 1'b0; xm_regwrite = 1'b1;
    alu_out = $urandom; xm_rd = 5'($urandom); mem_ack = 1'b1; mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    expRw = 1'b1; expM2r = 1'b0; expAlu = alu_out; expRd = xm_rd;
    checkMw("idleack");
    checkOutput("idleack.mem_req", 64'(mem_req), 64'd0);
    checkOutput("idleack.mdr", 64'(mdr), 64'(expMdr));
    checkOutput("idleack.err", 64'(err), 64'(expErr));
  endtask

  // Directed plan items first, then randomized operations, then reset mid-transaction
  initial begin
    rst = 1'b1;
    xm_memtoreg = 1'b0; xm_regwrite = 1'b0; xm_memread = 1'b0; xm_memwrite = 1'b0;
    alu_out = '0; xm_rd = '0; xm_md = '0; mem_ack = 1'b0; mem_rdata = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.mem_req",   64'(mem_req),   64'd0);
    checkOutput("reset.mem_we",    64'(mem_we),    64'd0);
    checkOutput("reset.mem_addr",  64'(mem_addr),  64'd0);
    checkOutput("reset.mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("reset.stall",     64'(stall),     64'd0);
    checkOutput("reset.mdr",       64'(mdr),       64'd0);
    checkOutput("reset.err",       64'(err),       64'd0);
    checkMw("reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 5'd5, 32'h0, 0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h85, 5'd3, 32'hDEADBEEF, 3, 32'hCAFE0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h01, 5'd8, 32'h0, 1, 32'h00000001);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 5'd9, 32'h0, 2, 32'h00000055);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h22, 5'd4, 32'h600D600D, 2, 32'hBADBAD00);
    idleAck();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h7F, 5'd12, 32'h0, 0, 32'h0);
    idleAck();

    for (int i = 0; i < 40; i++) begin
      int  kind;
      kind = $urandom_range(0, 3);
      applyStimulus(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom), 1'($urandom),
                    $urandom, 5'($urandom), $urandom, $urandom_range(0, 6), $urandom);
    end

    // Start a load, then assert reset in its second BUSY cycle
    @(negedge clk);
    xm_memread = 1'b1; xm_memwrite = 1'b0; xm_memtoreg = 1'b1; xm_regwrite = 1'b1;
    alu_out = 32'h3; xm_rd = 5'd7; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("midrst.mem_req", 64'(mem_req), 64'd0);
    checkOutput("midrst.stall",   64'(stall),   64'd0);
    checkOutput("midrst.mdr",     64'(mdr),     64'd0);
    checkOutput("midrst.err",     64'(err),     64'd0);
    checkMw("midrst");
    @(negedge clk);
    rst = 1'b0;
    xm_memread = 1'b0; xm_memtoreg = 1'b0; xm_regwrite = 1'b0; alu_out = '0; xm_rd = '0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput("lateack.mem_req", 64'(mem_req), 64'd0);
    checkOutput("lateack.stall",   64'(stall),   64'd0);
    checkOutput("lateack.mdr",     64'(mdr),     64'd0);
    checkOutput("lateack.err",     64'(err),     64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
